// File: rtl/uart_rx.sv
// uart_rx: dbus slave deframing 16x-oversampled 8N1 rx into a DEPTH-byte FIFO; byte visible 1 cycle after stop sample.
// ack 1 cycle after cyc; a full FIFO drops new bytes and sets overrun. UART_RX_IRQ_EN adds CTRL and irq.
module uart_rx #(
  parameter logic [7:0] ADDR   = 8'h60,
  parameter int         AWIDTH = 8,
  parameter int         DEPTH  = 8
) (
  input  logic        wb_clk,
  input  logic        wb_rst_n,
  input  logic [31:0] wb_dbus_adr,
  input  logic [31:0] wb_dbus_dat,
  input  logic [3:0]  wb_dbus_sel,
  input  logic        wb_dbus_we,
  input  logic        wb_dbus_cyc,
  output logic [31:0] rdt,
  output logic        ack,
  input  logic        baud16_en,
  input  logic        rx,
  output logic        irq
);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  state_t        state_q, state_d;
  logic [3:0]    tick_q, tick_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          rx_s1_q, rx_s2_q;
  logic          ack_q;
  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q, count_d;
  logic          ovr_q, ovr_d, ferr_q, ferr_d;
  logic          push, push_ok, pop, frame_bad, full, not_empty;
  logic          sel, acc_rd, acc_wr, ctrl_en;
  logic [1:0]    reg_idx;
  logic [3:0]    level;
  logic [31:0]   rd_data;
  logic          unused;

  assign sel     = wb_dbus_cyc && (wb_dbus_adr[31 -: AWIDTH] == ADDR[AWIDTH-1:0]);
  assign reg_idx = wb_dbus_adr[3:2];
  assign acc_rd  = ack_q & ~wb_dbus_we;
  assign acc_wr  = ack_q & wb_dbus_we;
  assign ack     = ack_q;
  assign rdt     = ack_q ? rd_data : 32'd0;

  assign full      = (count_q == (PW+1)'(DEPTH));
  assign not_empty = (count_q != '0);
  assign pop       = acc_rd && (reg_idx == 2'd0) && not_empty;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign push_ok   = push & (~full | pop);
  assign count_d   = count_q + (PW+1)'(push_ok) - (PW+1)'(pop);

  always_comb begin
    level   = (32'(count_q) > 32'd15) ? 4'd15 : 4'(count_q);
    rd_data = 32'd0;
    case (reg_idx)
      2'd0:    if (not_empty) rd_data = {23'd0, 1'b1, mem_q[rd_ptr_q]};
      2'd1:    rd_data = {24'd0, level, ferr_q, ovr_q, full, not_empty};
      2'd2:    rd_data = {31'd0, ctrl_en};
      default: rd_data = 32'd0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    push      = 1'b0;
    frame_bad = 1'b0;
    if (baud16_en) begin
      case (state_q)
        S_IDLE: if (!rx_s2_q) begin
          state_d = S_START;
          tick_d  = 4'd0;
        end
        S_START: begin
          tick_d = tick_q + 4'd1;
          if (tick_q == 4'd7) begin
            tick_d  = 4'd0;
            bit_d   = 3'd0;
            state_d = rx_s2_q ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          tick_d = tick_q + 4'd1;
          if (tick_q == 4'd15) begin
            shift_d = {rx_s2_q, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = S_STOP;
          end
        end
        S_STOP: begin
          tick_d = tick_q + 4'd1;
          if (tick_q == 4'd15) begin
            if (rx_s2_q) begin
              push    = 1'b1;
              state_d = S_IDLE;
            end else begin
              frame_bad = 1'b1;
              state_d   = S_BREAK;
            end
          end
        end
        S_BREAK: if (rx_s2_q) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Hardware set wins over a same-cycle write-1-to-clear.
  always_comb begin
    ovr_d  = ovr_q;
    ferr_d = ferr_q;
    if (acc_wr && reg_idx == 2'd1) begin
      if (wb_dbus_dat[2]) ovr_d  = 1'b0;
      if (wb_dbus_dat[3]) ferr_d = 1'b0;
    end
    if (push && full && !pop) ovr_d  = 1'b1;
    if (frame_bad)            ferr_d = 1'b1;
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      rx_s1_q  <= 1'b1;
      rx_s2_q  <= 1'b1;
      state_q  <= S_IDLE;
      tick_q   <= 4'd0;
      bit_q    <= 3'd0;
      shift_q  <= 8'd0;
      ack_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovr_q    <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      rx_s1_q  <= rx;
      rx_s2_q  <= rx_s1_q;
      state_q  <= state_d;
      tick_q   <= tick_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      ack_q    <= sel & ~ack_q;
      wr_ptr_q <= wr_ptr_q + PW'(push_ok);
      rd_ptr_q <= rd_ptr_q + PW'(pop);
      count_q  <= count_d;
      ovr_q    <= ovr_d;
      ferr_q   <= ferr_d;
    end
  end

  always_ff @(posedge wb_clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= shift_q;
  end

`ifdef UART_RX_IRQ_EN
  logic ctrl_q, ctrl_d, irq_q;

  assign ctrl_d  = (acc_wr && reg_idx == 2'd2) ? wb_dbus_dat[0] : ctrl_q;
  assign ctrl_en = ctrl_q;
  assign irq     = irq_q;

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      ctrl_q <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      ctrl_q <= ctrl_d;
      irq_q  <= ctrl_d & (count_d != '0);
    end
  end

  assign unused = ^{wb_dbus_sel, wb_dbus_adr[31-AWIDTH:4], wb_dbus_adr[1:0],
                    wb_dbus_dat[31:4], wb_dbus_dat[1]};
`else
  assign ctrl_en = 1'b0;
  assign irq     = 1'b0;
  assign unused  = ^{wb_dbus_sel, wb_dbus_adr[31-AWIDTH:4], wb_dbus_adr[1:0],
                     wb_dbus_dat[31:4], wb_dbus_dat[1:0]};
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: bus accesses queue expected rdt, a negedge monitor checks every ack.
module tb_uart_rx;
  localparam int BIT = 16 * 17;

`ifdef UART_RX_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic        clk, rst_n;
  logic [31:0] adr, dat, rdt;
  logic [3:0]  sel;
  logic        we, cyc, ack, baud16_en, rx, irq;

  int checks = 0;
  int errs   = 0;

  logic [32:0] exp_q [$];
  string       name_q [$];
  logic [32:0] mon_e;
  string       mon_nm;
  logic        prev_ack = 1'b0;

  uart_rx dut (
    .wb_clk      (clk),
    .wb_rst_n    (rst_n),
    .wb_dbus_adr (adr),
    .wb_dbus_dat (dat),
    .wb_dbus_sel (sel),
    .wb_dbus_we  (we),
    .wb_dbus_cyc (cyc),
    .rdt         (rdt),
    .ack         (ack),
    .baud16_en   (baud16_en),
    .rx          (rx),
    .irq         (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    baud16_en = 1'b0;
    forever begin
      repeat (16) @(posedge clk);
      #1 baud16_en = 1'b1;
      @(posedge clk);
      #1 baud16_en = 1'b0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, checks=%0d errors=%0d", checks, errs);
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ack) begin
      chk("ack_single_cycle", 32'(prev_ack), 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_ack", 32'd1, 32'd0);
      end else begin
        mon_e  = exp_q.pop_front();
        mon_nm = name_q.pop_front();
        if (mon_e[32]) chk(mon_nm, rdt, mon_e[31:0]);
      end
    end
    prev_ack = ack;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic w, input logic [1:0] ra, input logic [31:0] wdat,
                     input logic [31:0] exp, input string nm);
    int n;
    exp_q.push_back({~w, exp});
    name_q.push_back(nm);
    @(posedge clk);
    #1;
    adr = {8'h60, 20'h0, ra, 2'b00};
    we  = w;
    dat = wdat;
    cyc = 1'b1;
    n   = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack && n < 4);
    chk({nm, "_ack"}, 32'(ack), 32'd1);
    if (!ack) begin
      void'(exp_q.pop_front());
      void'(name_q.pop_front());
    end
    @(posedge clk);
    #1;
    cyc = 1'b0;
    we  = 1'b0;
    dat = 32'd0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(posedge clk);
    #1 rx = 1'b0;
    wait_cyc(BIT);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_cyc(BIT);
    end
    rx = stop;
    wait_cyc(BIT);
    rx = 1'b1;
    wait_cyc(40);
  endtask

  initial begin
    rst_n = 1'b0;
    adr   = 32'd0;
    dat   = 32'd0;
    sel   = 4'hF;
    we    = 1'b0;
    cyc   = 1'b0;
    rx    = 1'b1;
    wait_cyc(4);
    rst_n = 1'b1;

    @(negedge clk);
    chk("rst_rdt", rdt, 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    bus(1'b0, 2'd1, 32'd0, 32'd0, "rst_status");
    bus(1'b0, 2'd0, 32'd0, 32'd0, "rst_data");
    bus(1'b0, 2'd3, 32'd0, 32'd0, "reg3_read");

    @(posedge clk);
    #1;
    adr = 32'h5000_0004;
    cyc = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("unsel_ack", 32'(ack), 32'd0);
      chk("unsel_rdt", rdt, 32'd0);
    end
    @(posedge clk);
    #1 cyc = 1'b0;

    send_byte(8'hA5, 1'b1);
    bus(1'b0, 2'd1, 32'd0, 32'h11, "a5_status");
    bus(1'b1, 2'd0, 32'hFF, 32'd0, "data_write");
    bus(1'b0, 2'd1, 32'd0, 32'h11, "a5_status_after_wr");
    bus(1'b0, 2'd0, 32'd0, 32'h1A5, "a5_data");
    bus(1'b0, 2'd1, 32'd0, 32'h00, "a5_status_empty");

    @(posedge clk);
    #1 rx = 1'b0;
    wait_cyc(100);
    rx = 1'b1;
    wait_cyc(400);
    bus(1'b0, 2'd1, 32'd0, 32'h00, "glitch_status");

    send_byte(8'h3C, 1'b0);
    bus(1'b0, 2'd1, 32'd0, 32'h08, "ferr_status");
    bus(1'b1, 2'd1, 32'h08, 32'd0, "ferr_clear");
    bus(1'b0, 2'd1, 32'd0, 32'h00, "ferr_cleared");

    for (int i = 1; i <= 9; i++) send_byte(8'(i), 1'b1);
    bus(1'b0, 2'd1, 32'd0, 32'h87, "full_status");
    for (int i = 1; i <= 8; i++) bus(1'b0, 2'd0, 32'd0, 32'h100 + 32'(i), "fifo_data");
    bus(1'b0, 2'd0, 32'd0, 32'h000, "fifo_empty_data");
    bus(1'b0, 2'd1, 32'd0, 32'h04, "ovr_status");
    bus(1'b1, 2'd1, 32'h04, 32'd0, "ovr_clear");
    bus(1'b0, 2'd1, 32'd0, 32'h00, "ovr_cleared");

    bus(1'b1, 2'd2, 32'd1, 32'd0, "ctrl_write");
    bus(1'b0, 2'd2, 32'd0, 32'(IRQ_ON), "ctrl_read");
    @(negedge clk);
    chk("irq_idle", 32'(irq), 32'd0);
    send_byte(8'h55, 1'b1);
    @(negedge clk);
    chk("irq_set", 32'(irq), 32'(IRQ_ON));
    bus(1'b0, 2'd0, 32'd0, 32'h155, "irq_data");
    @(negedge clk);
    chk("irq_clear_after_pop", 32'(irq), 32'd0);

    send_byte(8'h5A, 1'b1);
    bus(1'b0, 2'd1, 32'd0, 32'h11, "pre_reset_status");
    @(posedge clk);
    #1 rx = 1'b0;
    wait_cyc(3 * BIT);
    rst_n = 1'b0;
    wait_cyc(3);
    rx    = 1'b1;
    rst_n = 1'b1;
    wait_cyc(2 * BIT);
    bus(1'b0, 2'd1, 32'd0, 32'h00, "midframe_reset_status");
    bus(1'b0, 2'd2, 32'd0, 32'h00, "midframe_reset_ctrl");
    send_byte(8'hC3, 1'b1);
    bus(1'b0, 2'd0, 32'd0, 32'h1C3, "post_reset_data");

    wait_cyc(2);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
